sha2_msg_sched: RTL and testbench

SHA2_MSG_SCHED -- requirements
Module: sha2_msg_sched

---
 rtl/sha2_msg_sched.sv | 135 +++++++++++++
 tb/tb_sha2_msg_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_msg_sched.sv
// SHA-2 message schedule generator: streams M[0..15] straight through, then
// expands the 16-word window into W[16..NUM_ROUNDS-1] under w_valid/w_ready.
module sha2_msg_sched #(
    parameter int WORD_W     = 32,
    parameter int NUM_ROUNDS = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_data,
    output logic [6:0]        w_t,
    output logic              w_last,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPAND = 2'd2;

    localparam logic [6:0] T_LOAD_LAST = 7'd15;
    localparam logic [6:0] T_LAST      = 7'(NUM_ROUNDS - 1);

    logic [1:0]              state_q, state_d;
    logic [6:0]              t_q, t_d;
    // Index 0 holds W[t-1] (newest), index 15 holds W[t-16] (oldest).
    logic [15:0][WORD_W-1:0] win_q, win_d;
    logic [WORD_W-1:0]       gen_word;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned       n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        if (WORD_W == 64)
            return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
        else
            return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        if (WORD_W == 64)
            return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
        else
            return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    always_comb begin
        gen_word = sigma1(win_q[1]) + win_q[6] + sigma0(win_q[14]) + win_q[15];
    end

    always_comb begin
        in_ready = 1'b0;
        w_valid  = 1'b0;
        w_data   = '0;
        w_t      = 7'd0;
        w_last   = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_LOAD: begin
                in_ready = w_ready;
                w_valid  = in_valid;
                w_data   = in_data;
                w_t      = t_q;
                busy     = 1'b1;
            end
            S_EXPAND: begin
                w_valid = 1'b1;
                w_data  = gen_word;
                w_t     = t_q;
                w_last  = (t_q == T_LAST);
                busy    = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        win_d   = win_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    t_d     = 7'd0;
                end
            end
            S_LOAD: begin
                if (in_valid && w_ready) begin
                    win_d = {win_q[14:0], in_data};
                    t_d   = t_q + 7'd1;
                    if (t_q == T_LOAD_LAST)
                        state_d = S_EXPAND;
                end
            end
            S_EXPAND: begin
                if (w_ready) begin
                    win_d = {win_q[14:0], gen_word};
                    if (t_q == T_LAST) begin
                        state_d = S_IDLE;
                        t_d     = 7'd0;
                    end else begin
                        t_d = t_q + 7'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                t_d     = 7'd0;
            end
        endcase
    end

    // Window is cleared on reset so an aborted block leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            t_q     <= 7'd0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            win_q   <= win_d;
        end
    end

endmodule

// File: tb/tb_sha2_msg_sched.sv
// Scoreboard bench for sha2_msg_sched: 32-bit and 64-bit instances checked
// against a software SHA-2 schedule model, with stalls, resets and start abuse.
module tb_sha2_msg_sched;

    logic        clk = 1'b0;
    logic        resetn, start, in_valid, w_ready, sel64;
    logic [63:0] in_data;
    logic        start32, start64;

    logic        in_ready32, w_valid32, w_last32, busy32;
    logic [31:0] w_data32;
    logic [6:0]  w_t32;
    logic        in_ready64, w_valid64, w_last64, busy64;
    logic [63:0] w_data64;
    logic [6:0]  w_t64;

    logic        o_in_ready, o_valid, o_last, o_busy;
    logic [63:0] o_data;
    logic [6:0]  o_t;

    typedef struct {
        logic [6:0]  t;
        logic [63:0] d;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] msg[16];
    logic [63:0] wexp[80];
    logic [63:0] got[80];
    int          n_chk, n_err;

    always #5 clk = ~clk;

    assign start32 = start & ~sel64;
    assign start64 = start & sel64;

    assign o_in_ready = sel64 ? in_ready64 : in_ready32;
    assign o_valid    = sel64 ? w_valid64 : w_valid32;
    assign o_last     = sel64 ? w_last64 : w_last32;
    assign o_busy     = sel64 ? busy64 : busy32;
    assign o_data     = sel64 ? w_data64 : {32'h0, w_data32};
    assign o_t        = sel64 ? w_t64 : w_t32;

    sha2_msg_sched #(.WORD_W(32), .NUM_ROUNDS(64)) dut32 (
        .clk(clk), .resetn(resetn), .start(start32), .in_valid(in_valid),
        .in_data(in_data[31:0]), .in_ready(in_ready32), .w_valid(w_valid32),
        .w_ready(w_ready), .w_data(w_data32), .w_t(w_t32), .w_last(w_last32),
        .busy(busy32)
    );

    sha2_msg_sched #(.WORD_W(64), .NUM_ROUNDS(80)) dut64 (
        .clk(clk), .resetn(resetn), .start(start64), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready64), .w_valid(w_valid64),
        .w_ready(w_ready), .w_data(w_data64), .w_t(w_t64), .w_last(w_last64),
        .busy(busy64)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] rr(input logic [63:0] x, input int n, input int w);
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        return ((x >> n) | (x << (w - n))) & m;
    endfunction

    task automatic model(input int w);
        logic [63:0] m, a, b, s0, s1;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        for (int t = 0; t < 16; t++) wexp[t] = msg[t] & m;
        for (int t = 16; t < 80; t++) begin
            a = wexp[t-15];
            b = wexp[t-2];
            if (w == 64) begin
                s0 = rr(a, 1, 64) ^ rr(a, 8, 64) ^ (a >> 7);
                s1 = rr(b, 19, 64) ^ rr(b, 61, 64) ^ (b >> 6);
            end else begin
                s0 = rr(a, 7, 32) ^ rr(a, 18, 32) ^ (a >> 3);
                s1 = rr(b, 17, 32) ^ rr(b, 19, 32) ^ (b >> 10);
            end
            wexp[t] = (s1 + wexp[t-7] + s0 + wexp[t-16]) & m;
        end
    endtask

    task automatic set_abc(input bit wide);
        for (int i = 0; i < 16; i++) msg[i] = 64'h0;
        msg[0]  = wide ? 64'h6162_6380_0000_0000 : 64'h0000_0000_6162_6380;
        msg[15] = 64'h18;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
    endtask

    // Entered and left at posedge+1 with the selected DUT idle.
    task automatic run_block(input bit rnd, input bit hold, input bit pulse, input int rst_at);
        int          w, nr, idx, cyc;
        bit          stalled, aborted;
        logic [63:0] held_d;
        logic [6:0]  held_t;
        exp_t        e;
        w  = sel64 ? 64 : 32;
        nr = sel64 ? 80 : 64;
        model(w);
        for (int t = 0; t < nr; t++) begin
            e.t = 7'(t); e.d = wexp[t]; e.last = (t == nr - 1);
            sb.push_back(e);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = hold;
        chk("busy_after_start", {63'h0, o_busy}, 64'h1);
        chk("t_after_start", {57'h0, o_t}, 64'h0);
        idx = 0; cyc = 0; stalled = 1'b0; aborted = 1'b0;
        held_d = '0; held_t = '0;
        while (sb.size() != 0 && cyc < 4000 && !aborted) begin
            if (rst_at >= 0 && o_busy && o_t == 7'(rst_at)) begin
                resetn = 1'b0;
                @(posedge clk); #1;
                resetn = 1'b1;
                start  = 1'b0;
                chk("rst_busy", {63'h0, o_busy}, 64'h0);
                chk("rst_valid", {63'h0, o_valid}, 64'h0);
                chk("rst_in_ready", {63'h0, o_in_ready}, 64'h0);
                chk("rst_t", {57'h0, o_t}, 64'h0);
                chk("rst_data", o_data, 64'h0);
                chk("rst_last", {63'h0, o_last}, 64'h0);
                sb.delete();
                aborted = 1'b1;
            end else begin
                in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data  = (idx < 16) ? msg[idx] : 64'h0;
                w_ready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                start    = hold || (pulse && (o_t == 7'd5 || o_t == 7'd30));
                @(negedge clk);
                if (stalled && o_valid) begin
                    chk("stall_data", o_data, held_d);
                    chk("stall_t", {57'h0, o_t}, {57'h0, held_t});
                end
                if (o_busy)
                    chk("in_ready", {63'h0, o_in_ready}, {63'h0, (o_t < 7'd16) && w_ready});
                if (o_valid && w_ready) begin
                    e = sb.pop_front();
                    chk("w_t", {57'h0, o_t}, {57'h0, e.t});
                    chk("w_data", o_data, e.d);
                    chk("w_last", {63'h0, o_last}, {63'h0, e.last});
                    got[e.t] = o_data;
                end
                stalled = o_valid && !w_ready && (o_t >= 7'd16);
                held_d  = o_data;
                held_t  = o_t;
                if (o_in_ready && in_valid) idx++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (sb.size() != 0) begin
            chk("word_timeout", 64'(sb.size()), 64'h0);
            sb.delete();
        end
        in_valid = 1'b0;
        if (!aborted) begin
            chk("idle_busy", {63'h0, o_busy}, 64'h0);
            chk("idle_valid", {63'h0, o_valid}, 64'h0);
            chk("idle_t", {57'h0, o_t}, 64'h0);
            chk("idle_data", o_data, 64'h0);
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        sel64 = 1'b0; resetn = 1'b0; start = 1'b0;
        in_valid = 1'b0; w_ready = 1'b0; in_data = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {63'h0, o_busy}, 64'h0);
        chk("reset_valid", {63'h0, o_valid}, 64'h0);
        chk("reset_in_ready", {63'h0, o_in_ready}, 64'h0);
        chk("reset_t", {57'h0, o_t}, 64'h0);
        chk("reset_data", o_data, 64'h0);
        chk("reset_last", {63'h0, o_last}, 64'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        set_abc(1'b0);
        run_block(1'b0, 1'b0, 1'b0, -1);
        chk("abc256_w16", got[16], 64'h6162_6380);
        chk("abc256_w17", got[17], 64'h000F_0000);

        run_block(1'b1, 1'b0, 1'b0, -1);
        chk("abc256_stall_w17", got[17], 64'h000F_0000);

        set_rand();
        run_block(1'b1, 1'b1, 1'b0, -1);
        set_rand();
        run_block(1'b0, 1'b0, 1'b0, -1);

        set_abc(1'b0);
        run_block(1'b0, 1'b0, 1'b1, -1);

        set_rand();
        run_block(1'b1, 1'b0, 1'b0, 20);
        set_rand();
        run_block(1'b0, 1'b0, 1'b0, -1);

        sel64 = 1'b1;
        set_abc(1'b1);
        run_block(1'b1, 1'b0, 1'b0, -1);
        chk("abc512_w16", got[16], 64'h6162_6380_0000_0000);
        chk("abc512_w17", got[17], 64'h0003_0000_0000_00C0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
